// File: rtl/ram_sp_pipe_if.sv
// Request/response channel between a requester (LSU/interconnect) and ram_sp_pipe.
// Signal names keep the memory-side _i/_o suffixes so both ends read the same.
interface ram_sp_pipe_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32
);
   logic                  req_i;
   logic                  we_i;
   logic [ADDR_W-1:0]     addr_i;
   logic [DATA_W/8-1:0]   wstrb_i;
   logic [DATA_W-1:0]     wdata_i;
   logic                  gnt_o;
   logic                  rvalid_o;
   logic [DATA_W-1:0]     rdata_o;
   logic                  err_o;
   logic                  rsp_ready_i;

   modport master (
      output req_i, we_i, addr_i, wstrb_i, wdata_i, rsp_ready_i,
      input  gnt_o, rvalid_o, rdata_o, err_o
   );

   modport slave (
      input  req_i, we_i, addr_i, wstrb_i, wdata_i, rsp_ready_i,
      output gnt_o, rvalid_o, rdata_o, err_o
   );
endinterface

// File: rtl/ram_sp_pipe.sv
// Single-port data RAM with byte strobes, 1- or 2-cycle read latency, response
// back-pressure and an out-of-range error flag; one in-order response per request.
module ram_sp_pipe #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned DEPTH    = 4096,
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned READ_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   ram_sp_pipe_if.slave  bus
);
   localparam int unsigned NB     = DATA_W / 8;
   localparam int unsigned OFF    = $clog2(NB);
   localparam int unsigned IDX_W  = ADDR_W - OFF;
   localparam int unsigned MEM_AW = $clog2(DEPTH);

   logic [IDX_W-1:0]  idx;
   logic [MEM_AW-1:0] widx;
   logic              oob;
   logic              stall;
   logic              accept;
   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              rvalid_q;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;
   logic              unused_addr;

   assign idx         = bus.addr_i[ADDR_W-1:OFF];
   assign widx        = idx[MEM_AW-1:0];
   assign oob         = (idx >= IDX_W'(DEPTH));
   assign unused_addr = ^bus.addr_i;

   // Any unconsumed response freezes the whole pipe and blocks new requests.
   assign stall     = rvalid_q & ~bus.rsp_ready_i;
   assign bus.gnt_o = ~stall & ~rst;
   assign accept    = bus.req_i & bus.gnt_o;

   assign rd_word = mem[widx];

   // Byte-lane write; out-of-range writes alias nothing and are dropped.
   always_ff @(posedge clk) begin : mem_write
      if (accept && bus.we_i && !oob) begin
         for (int unsigned k = 0; k < NB; k++) begin
            if (bus.wstrb_i[k]) mem[widx][8*k +: 8] <= bus.wdata_i[8*k +: 8];
         end
      end
   end

   if (READ_LAT == 1) begin : g_lat1
      always_ff @(posedge clk) begin : out_reg
         if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
         end else if (!stall) begin
            rvalid_q <= accept;
            rdata_q  <= (accept && !bus.we_i && !oob) ? rd_word : '0;
            err_q    <= accept & oob;
         end
      end
   end else begin : g_lat2
      logic              s1_v;
      logic              s1_we;
      logic              s1_oob;
      logic [DATA_W-1:0] s1_data;

      // Stage s1 captures the word at the accept edge; output register follows it.
      always_ff @(posedge clk) begin : pipe_reg
         if (rst) begin
            s1_v     <= 1'b0;
            s1_we    <= 1'b0;
            s1_oob   <= 1'b0;
            s1_data  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
         end else if (!stall) begin
            s1_v     <= accept;
            s1_we    <= bus.we_i;
            s1_oob   <= oob;
            s1_data  <= rd_word;
            rvalid_q <= s1_v;
            rdata_q  <= (s1_v && !s1_we && !s1_oob) ? s1_data : '0;
            err_q    <= s1_v & s1_oob;
         end
      end
   end

   assign bus.rvalid_o = rvalid_q;
   assign bus.rdata_o  = rdata_q;
   assign bus.err_o    = err_q;
endmodule

// File: tb/tb_ram_sp_pipe.sv
// Bench for ram_sp_pipe: READ_LAT=1 and READ_LAT=2 instances (DEPTH=256) checked
// against a queue/array response model plus directed literal expectations.
module tb_ram_sp_pipe;
   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 32;
   localparam int unsigned DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sel = 1'b0;
   logic        req = 1'b0;
   logic        we  = 1'b0;
   logic        rdy = 1'b1;
   logic [31:0] addr  = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;

   always #5 clk = ~clk;

   ram_sp_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();
   ram_sp_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) if2 ();

   assign if1.req_i = req & ~sel;
   assign if2.req_i = req & sel;
   assign if1.we_i = we;       assign if2.we_i = we;
   assign if1.addr_i = addr;   assign if2.addr_i = addr;
   assign if1.wstrb_i = wstrb; assign if2.wstrb_i = wstrb;
   assign if1.wdata_i = wdata; assign if2.wdata_i = wdata;
   assign if1.rsp_ready_i = rdy;
   assign if2.rsp_ready_i = rdy;

   ram_sp_pipe #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .READ_LAT(1)) u_lat1 (
      .clk(clk), .rst(rst), .bus(if1.slave));
   ram_sp_pipe #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .READ_LAT(2)) u_lat2 (
      .clk(clk), .rst(rst), .bus(if2.slave));

   wire        gnt = sel ? if2.gnt_o    : if1.gnt_o;
   wire        rv  = sel ? if2.rvalid_o : if1.rvalid_o;
   wire [31:0] rd  = sel ? if2.rdata_o  : if1.rdata_o;
   wire        er  = sel ? if2.err_o    : if1.err_o;
   int lat;
   always_comb lat = sel ? 2 : 1;

   typedef struct { logic [31:0] data; logic err; int acc; } exp_t;
   typedef struct { logic [31:0] data; logic err; int acc; int cyc; } log_t;

   exp_t        q[$];
   log_t        got[$];
   bit [31:0]   mm [2][DEPTH];
   int          cyc = 0;
   logic        rst_q = 1'b0;
   int          n_chk = 0;
   int          n_pass = 0;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Model: every accepted request yields one expected response, in order.
   exp_t        e;
   int unsigned midx;
   logic        moob;
   logic        hold_q = 1'b0;
   logic [31:0] prev_d;
   logic        prev_e;

   always @(negedge clk) begin
      if (rst) begin
         chk("gnt_in_rst", 32'(gnt), 32'd0);
         if (rst_q) begin
            chk("rvalid_rst", 32'(rv), 32'd0);
            chk("rdata_rst", rd, 32'd0);
            chk("err_rst", 32'(er), 32'd0);
         end
         q.delete();
         hold_q = 1'b0;
      end else begin
         if (rv) begin
            if (q.size() == 0) begin
               chk("spurious_rsp", 32'(rv), 32'd0);
            end else begin
               e = q[0];
               chk("rsp_data", rd, e.data);
               chk("rsp_err", 32'(er), 32'(e.err));
               if (hold_q) begin
                  chk("hold_data", rd, prev_d);
                  chk("hold_err", 32'(er), 32'(prev_e));
               end else begin
                  chk("latency_min", 32'((cyc - e.acc) >= lat), 32'd1);
               end
               if (rdy) begin
                  got.push_back('{rd, er, e.acc, cyc});
                  void'(q.pop_front());
               end
            end
            hold_q = ~rdy;
            prev_d = rd;
            prev_e = er;
         end else begin
            if (hold_q) chk("hold_valid", 32'(rv), 32'd1);
            hold_q = 1'b0;
         end
         if (req && gnt) begin
            midx = addr >> 2;
            moob = (midx >= DEPTH);
            e.data = (we || moob) ? 32'd0 : mm[int'(sel)][midx[7:0]];
            e.err  = moob;
            e.acc  = cyc;
            q.push_back(e);
            if (we && !moob) begin
               for (int k = 0; k < 4; k++)
                  if (wstrb[k]) mm[int'(sel)][midx[7:0]][8*k +: 8] = wdata[8*k +: 8];
            end
         end
      end
   end

   task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
      bit ok = 1'b0;
      we = w; addr = a; wstrb = s; wdata = d; req = 1'b1;
      for (int t = 0; t < 100 && !ok; t++) begin
         @(negedge clk);
         if (gnt) ok = 1'b1;
      end
      if (!ok) chk("grant_timeout", 32'(gnt), 32'd1);
      @(posedge clk); #1;
      req = 1'b0;
   endtask

   task automatic drain();
      bit done = 1'b0;
      for (int t = 0; t < 100 && !done; t++) begin
         @(posedge clk); #1;
         if (q.size() == 0 && !rv) done = 1'b1;
      end
      if (!done) chk("drain_timeout", 32'(rv), 32'd0);
   endtask

   task automatic chk_rsp(input string nm, input int i, input logic [31:0] d, input logic er_exp);
      if (got.size() > i) begin
         chk({nm, "_data"}, got[i].data, d);
         chk({nm, "_err"}, 32'(got[i].err), 32'(er_exp));
      end else begin
         chk({nm, "_missing"}, 32'(got.size()), 32'(i + 1));
      end
   endtask

   task automatic run_basic(input logic s);
      sel = s;
      issue(1'b1, 32'h0, 4'hF, 32'h01234567);
      issue(1'b1, 32'h4, 4'hF, 32'h89ABCDEF);
      issue(1'b1, 32'h8, 4'hF, 32'h0F1E2D3C);
      issue(1'b1, 32'hC, 4'hF, 32'h55AA55AA);
      drain();
      // byte strobes
      got.delete();
      issue(1'b1, 32'h10, 4'hF, 32'h11223344);
      issue(1'b1, 32'h10, 4'h5, 32'hAABBCCDD);
      issue(1'b0, 32'h10, 4'h0, 32'h0);
      drain();
      chk("strb_cnt", 32'(got.size()), 32'd3);
      chk_rsp("strb_wr", 0, 32'h0, 1'b0);
      chk_rsp("strb_rd", 2, 32'h11BB33DD, 1'b0);
      // latency with consecutive reads
      got.delete();
      issue(1'b0, 32'h0, 4'h0, 32'h0);
      issue(1'b0, 32'h4, 4'h0, 32'h0);
      issue(1'b0, 32'h8, 4'h0, 32'h0);
      drain();
      chk("lat_cnt", 32'(got.size()), 32'd3);
      chk_rsp("lat_r0", 0, 32'h01234567, 1'b0);
      chk_rsp("lat_r1", 1, 32'h89ABCDEF, 1'b0);
      chk_rsp("lat_r2", 2, 32'h0F1E2D3C, 1'b0);
      if (got.size() == 3) begin
         for (int i = 0; i < 3; i++) begin
            chk("lat_acc", 32'(got[i].acc), 32'(got[0].acc + i));
            chk("lat_cyc", 32'(got[i].cyc), 32'(got[0].acc + lat + i));
         end
      end
      // out-of-range: idx 256 aliases word 0 but must not touch it
      got.delete();
      issue(1'b1, 32'h400, 4'hF, 32'hFFFFFFFF);
      issue(1'b0, 32'h400, 4'h0, 32'h0);
      issue(1'b0, 32'h0, 4'h0, 32'h0);
      drain();
      chk_rsp("oob_wr", 0, 32'h0, 1'b1);
      chk_rsp("oob_rd", 1, 32'h0, 1'b1);
      chk_rsp("oob_w0", 2, 32'h01234567, 1'b0);
      // write then read the last word
      got.delete();
      issue(1'b1, 32'h3FC, 4'hF, 32'hDEADBEEF);
      issue(1'b0, 32'h3FC, 4'h0, 32'h0);
      drain();
      chk_rsp("wtr_wr", 0, 32'h0, 1'b0);
      chk_rsp("wtr_rd", 1, 32'hDEADBEEF, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int seen;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      run_basic(1'b0);
      run_basic(1'b1);

      // back-pressure on the 2-cycle pipe
      got.delete();
      rdy = 1'b0;
      fork
         begin
            issue(1'b0, 32'h0, 4'h0, 32'h0);
            issue(1'b0, 32'h4, 4'h0, 32'h0);
            issue(1'b0, 32'h8, 4'h0, 32'h0);
            issue(1'b0, 32'hC, 4'h0, 32'h0);
         end
         begin
            for (int t = 0; t < 50 && !rv; t++) @(negedge clk);
            repeat (5) begin
               @(negedge clk);
               chk("bp_gnt", 32'(gnt), 32'd0);
            end
            @(posedge clk); #1;
            rdy = 1'b1;
         end
      join
      drain();
      chk("bp_cnt", 32'(got.size()), 32'd4);
      chk_rsp("bp_r0", 0, 32'h01234567, 1'b0);
      chk_rsp("bp_r1", 1, 32'h89ABCDEF, 1'b0);
      chk_rsp("bp_r2", 2, 32'h0F1E2D3C, 1'b0);
      chk_rsp("bp_r3", 3, 32'h55AA55AA, 1'b0);

      // reset mid-stream with responses pending
      got.delete();
      rdy = 1'b0;
      issue(1'b1, 32'h20, 4'hF, 32'hCAFEF00D);
      issue(1'b0, 32'h0, 4'h0, 32'h0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      rdy = 1'b1;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (rv) seen++;
      end
      chk("rst_no_stale", 32'(seen), 32'd0);
      chk("rst_log_empty", 32'(got.size()), 32'd0);
      issue(1'b0, 32'h20, 4'h0, 32'h0);
      drain();
      chk_rsp("rst_kept", 0, 32'hCAFEF00D, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
